matrix_op_t: RTL and testbench

- Single-source matrix transpose engine in the matrix-op subsystem.
- Reads a source matrix (metadata plus row-major data) from the shared matrix BRAM through a 1-cycle-latency read port.
- Streams the transposed elements to the matrix writer, always targeting result slot 0.
- Reports completion or error through busy/status.

---
 rtl/matrix_op_t_if.sv | 47 ++++
 rtl/matrix_op_t.sv | 242 ++++++++++++++++++++++++
 tb/tb_matrix_op_t.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_op_t_if.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_op_t_if
//  Purpose  : Bundles the control, BRAM read port and matrix-writer session
//             signals of the transpose engine.
//  Ports    : master modport = engine side (drives read_addr, writer session,
//             busy/status); slave modport = environment side (start, BRAM
//             read data, writer handshakes).
//  Revision : 1.0 - initial release
// ============================================================================
interface matrix_op_t_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    // Control / status
    logic                  start;
    logic [2:0]            matrix_src_id;
    logic                  busy;
    logic [2:0]            status;
    // BRAM read port (1-cycle latency)
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] data_out;
    // Matrix writer session
    logic                  write_request;
    logic                  write_ready;
    logic [2:0]            matrix_id;
    logic [7:0]            actual_rows;
    logic [7:0]            actual_cols;
    logic [7:0]            matrix_name [0:7];
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid;
    logic                  writer_ready;
    logic                  write_done;

    modport master (
        input  start, matrix_src_id, data_out, write_ready, writer_ready, write_done,
        output busy, status, read_addr, write_request, matrix_id, actual_rows,
               actual_cols, matrix_name, data_in, data_valid
    );

    modport slave (
        output start, matrix_src_id, data_out, write_ready, writer_ready, write_done,
        input  busy, status, read_addr, write_request, matrix_id, actual_rows,
               actual_cols, matrix_name, data_in, data_valid
    );
endinterface
`default_nettype wire

// File: rtl/matrix_op_t.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_op_t
//  Purpose  : Single-source matrix transpose engine. Reads metadata and
//             row-major data of a source slot from the matrix BRAM and streams
//             the transposed elements to the matrix writer (result slot 0).
//  Ports    : clk  - rising-edge clock
//             rst  - synchronous active-high reset
//             bus  - matrix_op_t_if.master (control, BRAM read, writer session)
//  Revision : 1.0 - initial release
// ============================================================================
module matrix_op_t #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int BLOCK_SIZE = 64,
    parameter int META_WORDS = 3
) (
    input  wire logic     clk,
    input  wire logic     rst,
    matrix_op_t_if.master bus
);

    localparam logic [4:0] c_st_idle             = 5'd0;
    localparam logic [4:0] c_st_check_id         = 5'd1;
    localparam logic [4:0] c_st_read_meta_addr   = 5'd2;
    localparam logic [4:0] c_st_read_meta_wait   = 5'd3;
    localparam logic [4:0] c_st_validate         = 5'd4;
    localparam logic [4:0] c_st_wait_write_ready = 5'd5;
    localparam logic [4:0] c_st_assert_write_req = 5'd6;
    localparam logic [4:0] c_st_wait_writer_en   = 5'd7;
    localparam logic [4:0] c_st_prepare_src_addr = 5'd8;
    localparam logic [4:0] c_st_read_src_wait    = 5'd9;
    localparam logic [4:0] c_st_wait_writer_data = 5'd10;
    localparam logic [4:0] c_st_update_indices   = 5'd11;
    localparam logic [4:0] c_st_wait_write_done  = 5'd12;
    localparam logic [4:0] c_st_done             = 5'd13;

    localparam logic [2:0] c_stat_idle      = 3'd0;
    localparam logic [2:0] c_stat_success   = 3'd1;
    localparam logic [2:0] c_stat_err_dim   = 3'd2;
    localparam logic [2:0] c_stat_err_id    = 3'd3;
    localparam logic [2:0] c_stat_err_empty = 3'd4;

    localparam int c_capacity = BLOCK_SIZE - META_WORDS;

    logic [4:0]            r_state_q,      w_state_d;
    logic [2:0]            r_src_id_q,     w_src_id_d;
    logic [7:0]            r_rows_q,       w_rows_d;
    logic [7:0]            r_cols_q,       w_cols_d;
    logic [7:0]            r_r_q,          w_r_d;
    logic [7:0]            r_c_q,          w_c_d;
    logic                  r_busy_q,       w_busy_d;
    logic [2:0]            r_status_q,     w_status_d;
    logic [ADDR_WIDTH-1:0] r_read_addr_q,  w_read_addr_d;
    logic                  r_write_req_q,  w_write_req_d;
    logic [2:0]            r_matrix_id_q,  w_matrix_id_d;
    logic [7:0]            r_act_rows_q,   w_act_rows_d;
    logic [7:0]            r_act_cols_q,   w_act_cols_d;
    logic [7:0]            r_name_q [0:7];
    logic [7:0]            w_name_d [0:7];
    logic [DATA_WIDTH-1:0] r_data_in_q,    w_data_in_d;
    logic                  r_data_valid_q, w_data_valid_d;

    logic [ADDR_WIDTH-1:0] w_base;
    logic [15:0]           w_elems;
    logic [7:0]            w_r_next;
    logic [7:0]            w_c_next;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_elem_addr;

    assign w_base  = ADDR_WIDTH'(32'(r_src_id_q) * BLOCK_SIZE);
    assign w_elems = 16'({8'd0, r_rows_q} * {8'd0, r_cols_q});

    // Walk the result row-major: the source-row index c is the fast index,
    // the source-column index r advances when c wraps.
    always_comb begin
        w_c_next = r_c_q;
        w_r_next = r_r_q;
        w_last   = 1'b0;
        if ((32'(r_c_q) + 32'd1) < 32'(r_rows_q)) begin
            w_c_next = r_c_q + 8'd1;
        end else begin
            w_c_next = 8'd0;
            if ((32'(r_r_q) + 32'd1) < 32'(r_cols_q)) begin
                w_r_next = r_r_q + 8'd1;
            end else begin
                w_last = 1'b1;
            end
        end
    end

    assign w_elem_addr = w_base + ADDR_WIDTH'(META_WORDS)
                       + ADDR_WIDTH'(32'(w_c_next) * 32'(r_cols_q) + 32'(w_r_next));

    // State register and all datapath/output flops
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= c_st_idle;
            r_src_id_q     <= '0;
            r_rows_q       <= '0;
            r_cols_q       <= '0;
            r_r_q          <= '0;
            r_c_q          <= '0;
            r_busy_q       <= 1'b0;
            r_status_q     <= c_stat_idle;
            r_read_addr_q  <= '0;
            r_write_req_q  <= 1'b0;
            r_matrix_id_q  <= '0;
            r_act_rows_q   <= '0;
            r_act_cols_q   <= '0;
            r_name_q       <= '{default: 8'h00};
            r_data_in_q    <= '0;
            r_data_valid_q <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_src_id_q     <= w_src_id_d;
            r_rows_q       <= w_rows_d;
            r_cols_q       <= w_cols_d;
            r_r_q          <= w_r_d;
            r_c_q          <= w_c_d;
            r_busy_q       <= w_busy_d;
            r_status_q     <= w_status_d;
            r_read_addr_q  <= w_read_addr_d;
            r_write_req_q  <= w_write_req_d;
            r_matrix_id_q  <= w_matrix_id_d;
            r_act_rows_q   <= w_act_rows_d;
            r_act_cols_q   <= w_act_cols_d;
            r_name_q       <= w_name_d;
            r_data_in_q    <= w_data_in_d;
            r_data_valid_q <= w_data_valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_st_idle:             if (bus.start) w_state_d = c_st_check_id;
            c_st_check_id:         w_state_d = (r_src_id_q == 3'd0) ? c_st_done : c_st_read_meta_addr;
            c_st_read_meta_addr:   w_state_d = c_st_read_meta_wait;
            c_st_read_meta_wait:   w_state_d = c_st_validate;
            c_st_validate: begin
                if ((r_rows_q == 8'd0) || (r_cols_q == 8'd0) || (32'(w_elems) > c_capacity))
                    w_state_d = c_st_done;
                else
                    w_state_d = c_st_wait_write_ready;
            end
            c_st_wait_write_ready: if (bus.write_ready) w_state_d = c_st_assert_write_req;
            c_st_assert_write_req: w_state_d = c_st_wait_writer_en;
            c_st_wait_writer_en:   if (bus.writer_ready) w_state_d = c_st_prepare_src_addr;
            c_st_prepare_src_addr: w_state_d = c_st_read_src_wait;
            c_st_read_src_wait:    w_state_d = c_st_wait_writer_data;
            c_st_wait_writer_data: if (bus.writer_ready) w_state_d = c_st_update_indices;
            c_st_update_indices:   w_state_d = w_last ? c_st_wait_write_done : c_st_prepare_src_addr;
            c_st_wait_write_done:  if (bus.write_done) w_state_d = c_st_done;
            c_st_done:             w_state_d = c_st_idle;
            default:               w_state_d = c_st_idle;
        endcase
    end

    // Output / datapath logic. read_addr is loaded on the transition into the
    // state that presents it, so BRAM data is valid in the following state.
    always_comb begin
        w_src_id_d     = r_src_id_q;
        w_rows_d       = r_rows_q;
        w_cols_d       = r_cols_q;
        w_r_d          = r_r_q;
        w_c_d          = r_c_q;
        w_busy_d       = r_busy_q;
        w_status_d     = r_status_q;
        w_read_addr_d  = r_read_addr_q;
        w_write_req_d  = 1'b0;
        w_matrix_id_d  = r_matrix_id_q;
        w_act_rows_d   = r_act_rows_q;
        w_act_cols_d   = r_act_cols_q;
        w_name_d       = r_name_q;
        w_data_in_d    = r_data_in_q;
        w_data_valid_d = 1'b0;
        case (r_state_q)
            c_st_idle: begin
                if (bus.start) begin
                    w_src_id_d = bus.matrix_src_id;
                    w_busy_d   = 1'b1;
                    w_status_d = c_stat_idle;
                end
            end
            c_st_check_id: begin
                if (r_src_id_q == 3'd0) w_status_d    = c_stat_err_id;
                else                    w_read_addr_d = w_base;
            end
            c_st_read_meta_wait: begin
                w_rows_d = bus.data_out[DATA_WIDTH-1 -: 8];
                w_cols_d = bus.data_out[DATA_WIDTH-9 -: 8];
            end
            c_st_validate: begin
                if ((r_rows_q == 8'd0) || (r_cols_q == 8'd0)) w_status_d = c_stat_err_empty;
                else if (32'(w_elems) > c_capacity)          w_status_d = c_stat_err_dim;
            end
            c_st_wait_write_ready: begin
                w_matrix_id_d = 3'd0;
                w_act_rows_d  = r_cols_q;
                w_act_cols_d  = r_rows_q;
                w_name_d      = '{8'h54, 8'h52, 8'h41, 8'h4E, 8'h53, 8'h00, 8'h00, 8'h00};
                if (bus.write_ready) w_write_req_d = 1'b1;
            end
            c_st_wait_writer_en: begin
                if (bus.writer_ready) begin
                    w_r_d         = 8'd0;
                    w_c_d         = 8'd0;
                    w_read_addr_d = w_base + ADDR_WIDTH'(META_WORDS);
                end
            end
            c_st_wait_writer_data: begin
                if (bus.writer_ready) begin
                    w_data_in_d    = bus.data_out;
                    w_data_valid_d = 1'b1;
                end
            end
            c_st_update_indices: begin
                w_r_d = w_r_next;
                w_c_d = w_c_next;
                if (!w_last) w_read_addr_d = w_elem_addr;
            end
            c_st_wait_write_done: if (bus.write_done) w_status_d = c_stat_success;
            c_st_done:            w_busy_d = 1'b0;
            default: ;
        endcase
    end

    assign bus.busy          = r_busy_q;
    assign bus.status        = r_status_q;
    assign bus.read_addr     = r_read_addr_q;
    assign bus.write_request = r_write_req_q;
    assign bus.matrix_id     = r_matrix_id_q;
    assign bus.actual_rows   = r_act_rows_q;
    assign bus.actual_cols   = r_act_cols_q;
    assign bus.matrix_name   = r_name_q;
    assign bus.data_in       = r_data_in_q;
    assign bus.data_valid    = r_data_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_op_t.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matrix_op_t
//  Purpose  : Directed self-checking bench for matrix_op_t with a BRAM model
//             and a matrix-writer model that captures result slot 0.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_op_t;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int BS = 16;
    localparam int MW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matrix_op_t_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    matrix_op_t #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS), .META_WORDS(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:255];
    logic [31:0] res [0:15];
    always @(posedge clk) bus.data_out <= mem[bus.read_addr];

    int n_cmp  = 0;
    int n_fail = 0;
    int stall_len = 0;

    // Writer model: evaluated on the falling edge
    int w_state = 0, w_cnt = 0, w_k = 0, w_stall = 0, n_req = 0;
    logic [2:0] req_id = 3'd7;
    always @(negedge clk) begin
        if (rst) begin
            w_state = 0; w_stall = 0;
            bus.write_ready = 1'b1; bus.writer_ready = 1'b0; bus.write_done = 1'b0;
        end else begin
            case (w_state)
                0: begin
                    bus.write_done = 1'b0; bus.write_ready = 1'b1;
                    if (bus.write_request) begin
                        n_req++;
                        req_id = bus.matrix_id;
                        for (int i = 0; i < 16; i++) res[i] = 32'hDEAD_BEEF;
                        res[0] = {bus.actual_rows, bus.actual_cols, 16'h0};
                        res[1] = {bus.matrix_name[0], bus.matrix_name[1], bus.matrix_name[2], bus.matrix_name[3]};
                        res[2] = {bus.matrix_name[4], bus.matrix_name[5], bus.matrix_name[6], bus.matrix_name[7]};
                        w_cnt = int'(bus.actual_rows) * int'(bus.actual_cols);
                        w_k = 0; w_stall = 0;
                        bus.write_ready = 1'b0; bus.writer_ready = 1'b1;
                        w_state = 1;
                    end
                end
                1: begin
                    if (bus.data_valid) begin
                        if (MW + w_k < 16) res[MW + w_k] = bus.data_in;
                        w_k++;
                        if (w_k >= w_cnt) begin
                            bus.writer_ready = 1'b0; w_state = 2;
                        end else if (stall_len > 0) begin
                            bus.writer_ready = 1'b0; w_stall = stall_len;
                        end
                    end else if (w_stall > 0) begin
                        w_stall--;
                        if (w_stall == 0) bus.writer_ready = 1'b1;
                    end
                end
                2: begin bus.write_done = 1'b1; w_state = 3; end
                default: begin bus.write_done = 1'b0; bus.write_ready = 1'b1; w_state = 0; end
            endcase
        end
    end

    // Activity monitors
    int busy_total = 0, n_dv = 0, rd_nz = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.busy) busy_total++;
            if (bus.data_valid) n_dv++;
            if (bus.read_addr != '0) rd_nz++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string p);
        check({p, "_busy"},    32'(bus.busy), 0);
        check({p, "_status"},  32'(bus.status), 0);
        check({p, "_raddr"},   32'(bus.read_addr), 0);
        check({p, "_wreq"},    32'(bus.write_request), 0);
        check({p, "_dvalid"},  32'(bus.data_valid), 0);
        check({p, "_din"},     bus.data_in, 0);
        check({p, "_mid"},     32'(bus.matrix_id), 0);
        check({p, "_rows"},    32'(bus.actual_rows), 0);
        check({p, "_cols"},    32'(bus.actual_cols), 0);
        check({p, "_name"},    {bus.matrix_name[0], bus.matrix_name[1], bus.matrix_name[2], bus.matrix_name[3]}
                             | {bus.matrix_name[4], bus.matrix_name[5], bus.matrix_name[6], bus.matrix_name[7]}, 0);
    endtask

    task automatic pulse_start(input logic [2:0] id);
        @(negedge clk); bus.matrix_src_id = id; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string p);
        bit to = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (!bus.busy) begin to = 1'b0; break; end
            @(negedge clk);
        end
        check({p, "_timeout"}, 32'(to), 0);
    endtask

    task automatic run_op(input string p, input logic [2:0] id, output int bcyc);
        int b0 = busy_total;
        pulse_start(id);
        wait_idle(p);
        bcyc = busy_total - b0;
    endtask

    task automatic check_2x3(input string p);
        check({p, "_meta"},  res[0], 32'h0302_0000);
        check({p, "_name0"}, res[1], 32'h5452_414E);
        check({p, "_name1"}, res[2], 32'h5300_0000);
        check({p, "_e0"}, res[3], 1);
        check({p, "_e1"}, res[4], 4);
        check({p, "_e2"}, res[5], 2);
        check({p, "_e3"}, res[6], 5);
        check({p, "_e4"}, res[7], 3);
        check({p, "_e5"}, res[8], 6);
    endtask

    int bc, r0, d0;
    bit to;

    initial begin
        bus.start = 1'b0;
        bus.matrix_src_id = 3'd0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        // slot 1: 2x3 [1 2 3; 4 5 6]
        mem[16] = 32'h0203_0000; mem[17] = 32'h4142_4344; mem[18] = 32'h4546_4748;
        for (int i = 0; i < 6; i++) mem[19 + i] = 32'(i + 1);
        // slot 2: 3x1 [7; 8; 9]
        mem[32] = 32'h0301_0000; mem[35] = 7; mem[36] = 8; mem[37] = 9;
        // slot 3: empty (0x0)
        mem[48] = 32'h0000_0000;
        // slot 4: 2x7 = 14 elements, one more than a slot holds
        mem[64] = 32'h0207_0000;
        // slot 5: 1x13, exactly fills a slot
        mem[80] = 32'h010D_0000;
        for (int i = 0; i < 13; i++) mem[83 + i] = 32'(100 + i);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Source id 0 is the destination slot
        r0 = n_req;
        run_op("errid", 3'd0, bc);
        check("errid_status", 32'(bus.status), 3);
        check("errid_busy_len", 32'(bc >= 2), 1);
        check("errid_no_reads", rd_nz, 0);
        check("errid_no_req", n_req - r0, 0);

        // 2x3 transpose, writer always ready
        r0 = n_req; d0 = n_dv;
        run_op("t23", 3'd1, bc);
        check("t23_status", 32'(bus.status), 1);
        check("t23_req_count", n_req - r0, 1);
        check("t23_req_id", 32'(req_id), 0);
        check("t23_dv_count", n_dv - d0, 6);
        check_2x3("t23");
        repeat (3) @(negedge clk);
        check("t23_status_hold", 32'(bus.status), 1);

        // 3x1 transpose
        d0 = n_dv;
        run_op("t31", 3'd2, bc);
        check("t31_status", 32'(bus.status), 1);
        check("t31_meta", res[0], 32'h0103_0000);
        check("t31_e0", res[3], 7);
        check("t31_e1", res[4], 8);
        check("t31_e2", res[5], 9);
        check("t31_dv_count", n_dv - d0, 3);

        // Empty matrix
        r0 = n_req;
        run_op("empty", 3'd3, bc);
        check("empty_status", 32'(bus.status), 4);
        check("empty_busy_len", 32'(bc >= 2), 1);
        check("empty_no_req", n_req - r0, 0);

        // One element too many for a slot
        r0 = n_req;
        run_op("dim", 3'd4, bc);
        check("dim_status", 32'(bus.status), 2);
        check("dim_no_req", n_req - r0, 0);

        // Exactly fills a slot
        d0 = n_dv;
        run_op("full", 3'd5, bc);
        check("full_status", 32'(bus.status), 1);
        check("full_meta", res[0], 32'h0D01_0000);
        check("full_first", res[3], 100);
        check("full_last", res[15], 112);
        check("full_dv_count", n_dv - d0, 13);

        // Writer stalls 3 cycles between elements; a start mid-operation is ignored
        stall_len = 3;
        r0 = n_req; d0 = n_dv;
        pulse_start(3'd1);
        repeat (12) @(negedge clk);
        pulse_start(3'd3);
        wait_idle("stall");
        check("stall_status", 32'(bus.status), 1);
        check("stall_req_count", n_req - r0, 1);
        check("stall_dv_count", n_dv - d0, 6);
        check_2x3("stall");
        repeat (4) @(negedge clk);
        check("stall_restart_ignored", 32'(bus.busy), 0);

        // Reset while the engine waits for the writer with an element pending
        stall_len = 8;
        d0 = n_dv;
        pulse_start(3'd1);
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (n_dv != d0) begin to = 1'b0; break; end
            @(negedge clk);
        end
        check("midrst_first_elem_timeout", 32'(to), 0);
        repeat (4) @(negedge clk);
        check("midrst_busy_before", 32'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(negedge clk);
        stall_len = 0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        d0 = n_dv;
        run_op("after_rst", 3'd1, bc);
        check("after_rst_status", 32'(bus.status), 1);
        check("after_rst_dv_count", n_dv - d0, 6);
        check_2x3("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
